// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT_DONE, ARB_GAP} arb_state_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational rotating-priority picker, search starts just after ptr
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  logic [IDX_W-1:0] idx;

  // Walk from the lowest priority slot to the highest so the last hit wins.
  always_comb begin
    winner  = '0;
    idx     = '0;
    any_req = |req;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx between NUM_REQ producers
// Optional per-requester frame counters on output byte_cnt when UART_TX_ARB_STATS_EN is defined.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int PACK_SIZE     = 8,
  parameter int ISSUE_TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*PACK_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_byte_valid,
  output logic [PACK_SIZE-1:0]           tx_byte_data,
  input  logic                           tx_active,
  input  logic                           tx_done,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy,
  output logic                           issue_err
`ifdef UART_TX_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]      byte_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ISSUE_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE      = ARB_IDLE;
  localparam logic [1:0] S_ISSUE     = ARB_ISSUE;
  localparam logic [1:0] S_WAIT_DONE = ARB_WAIT_DONE;
  localparam logic [1:0] S_GAP       = ARB_GAP;

  logic [1:0]           state;
  logic [IDX_W-1:0]     grant_q;
  logic [PACK_SIZE-1:0] data_q;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     winner;
  logic                 any_req;
  logic [PACK_SIZE-1:0] pick_data;

  // grant_q doubles as the round-robin pointer: the last winner has lowest priority.
  uart_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req     (req_valid),
    .ptr     (grant_q),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (winner == IDX_W'(i)) pick_data = req_data[i*PACK_SIZE +: PACK_SIZE];
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == S_IDLE && any_req) req_ready[winner] = 1'b1;
  end

  assign tx_byte_valid = (state == S_ISSUE);
  assign tx_byte_data  = data_q;
  assign grant_id      = grant_q;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      grant_q   <= '0;
      data_q    <= '0;
      cnt       <= '0;
      issue_err <= 1'b0;
    end else begin
      issue_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            data_q  <= pick_data;
            grant_q <= winner;
            cnt     <= '0;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (tx_active) begin
            state <= S_WAIT_DONE;
          end else if (cnt == CNT_W'(ISSUE_TIMEOUT - 1)) begin
            issue_err <= 1'b1;
            state     <= S_IDLE;
          end else if (cnt != CNT_W'(ISSUE_TIMEOUT)) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_DONE: if (tx_done) state <= S_GAP;
        S_GAP:       state <= S_IDLE;
        default:     state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_TX_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
    end else if (state == S_WAIT_DONE && tx_done) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (grant_q == IDX_W'(i))
          byte_cnt[i*STAT_W +: STAT_W] <= byte_cnt[i*STAT_W +: STAT_W] + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_byte_valid;
  logic [W-1:0]   tx_byte_data;
  logic           tx_active;
  logic           tx_done;
  logic [1:0]     grant_id;
  logic           busy;
  logic           issue_err;
`ifdef UART_TX_ARB_STATS_EN
  logic [N*16-1:0] byte_cnt;
`endif

  uart_tx_arbiter #(.NUM_REQ(N), .PACK_SIZE(W), .ISSUE_TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .tx_byte_valid (tx_byte_valid),
    .tx_byte_data  (tx_byte_data),
    .tx_active     (tx_active),
    .tx_done       (tx_done),
    .grant_id      (grant_id),
    .busy          (busy),
    .issue_err     (issue_err)
`ifdef UART_TX_ARB_STATS_EN
    ,
    .byte_cnt      (byte_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;

  typedef struct {
    logic [N-1:0]   valid;
    logic [N*W-1:0] data;
    int             exp_win;
    logic [W-1:0]   exp_byte;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: the winner is the first valid requester found going upward from last winner + 1.
  function automatic int model_pick(input logic [N-1:0] v);
    int w;
    w = -1;
    for (int k = 1; k <= N; k++)
      if (w < 0 && v[(model_ptr + k) % N]) w = (model_ptr + k) % N;
    return w;
  endfunction

  task automatic run_frame(input logic [N-1:0] v, input logic [N*W-1:0] d, input int exp_win,
                           input logic [W-1:0] exp_byte, input int act_dly, input int done_dly,
                           input logic noise);
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    #1;
    check("idle_busy", busy, 0);
    check("req_ready", req_ready, 32'(1) << exp_win);
    @(negedge clk);
    req_valid = noise ? N'($urandom) : '0;
    req_data  = $urandom;
    #1;
    check("issue_valid", tx_byte_valid, 1);
    check("issue_data", tx_byte_data, exp_byte);
    check("grant_id", grant_id, exp_win);
    check("ready_busy", req_ready, 0);
    check("issue_busy", busy, 1);
    for (int i = 0; i < act_dly; i++) begin
      tx_done = noise ? 1'($urandom) : 1'b0;
      @(negedge clk);
      #1;
      check("issue_hold", tx_byte_valid, 1);
      check("ready_busy", req_ready, 0);
    end
    tx_done   = 1'b0;
    tx_active = 1'b1;
    @(negedge clk);
    #1;
    check("wait_valid_drop", tx_byte_valid, 0);
    check("wait_busy", busy, 1);
    for (int i = 0; i < done_dly; i++) begin
      @(negedge clk);
      #1;
      check("wait_hold", busy, 1);
      check("ready_busy", req_ready, 0);
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done   = 1'b0;
    tx_active = 1'b0;
    req_valid = '0;
    #1;
    check("gap_busy", busy, 1);
    check("gap_valid", tx_byte_valid, 0);
    @(negedge clk);
    #1;
    check("back_idle", busy, 0);
    check("no_issue_err", issue_err, 0);
    model_ptr = exp_win;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int w;
    int first;
    int lat;
    int ready_cnt;
    logic [N-1:0]   v;
    logic [N*W-1:0] d;

    vecs[0]  = '{4'b1111, 32'h44332211, 1, 8'h22};
    vecs[1]  = '{4'b1111, 32'h44332211, 2, 8'h33};
    vecs[2]  = '{4'b1111, 32'h44332211, 3, 8'h44};
    vecs[3]  = '{4'b1111, 32'h44332211, 0, 8'h11};
    vecs[4]  = '{4'b0001, 32'h000000A5, 0, 8'hA5};
    vecs[5]  = '{4'b0001, 32'h0000005A, 0, 8'h5A};
    vecs[6]  = '{4'b1010, 32'hDDCCBBAA, 1, 8'hBB};
    vecs[7]  = '{4'b1010, 32'hDDCCBBAA, 3, 8'hDD};
    vecs[8]  = '{4'b1010, 32'hDDCCBBAA, 1, 8'hBB};
    vecs[9]  = '{4'b1010, 32'hDDCCBBAA, 3, 8'hDD};
    vecs[10] = '{4'b0100, 32'hDDCCBBAA, 2, 8'hCC};
    vecs[11] = '{4'b0011, 32'hDDCCBBAA, 0, 8'hAA};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    repeat (2) @(negedge clk);
    req_valid = 4'b1111;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_tx_valid", tx_byte_valid, 0);
    check("rst_tx_data", tx_byte_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_issue_err", issue_err, 0);
    rst       = 1'b0;
    req_valid = '0;

    for (int i = 0; i < 12; i++)
      run_frame(vecs[i].valid, vecs[i].data, vecs[i].exp_win, vecs[i].exp_byte, 1, 1, 1'b0);

    // ISSUE timeout with tx_active stuck low
    @(negedge clk);
    req_valid = 4'b1000;
    req_data  = 32'h77000000;
    #1;
    w = model_pick(4'b1000);
    check("to_ready", req_ready, 32'(1) << w);
    @(negedge clk);
    req_valid = '0;
    first = -1;
    for (int k = 1; k <= 40 && first < 0; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (k == 1) check("to_data", tx_byte_data, 8'h77);
      if (k == 16) check("to_valid_last", tx_byte_valid, 1);
      if (issue_err) first = k;
    end
    check("to_cycle", first, 17);
    check("to_busy", busy, 0);
    check("to_valid", tx_byte_valid, 0);
    @(negedge clk);
    #1;
    check("to_pulse_width", issue_err, 0);
    model_ptr = w;

    for (int r = 0; r < 40; r++) begin
      v = N'($urandom_range(0, 15));
      d = $urandom;
      if (v == '0) begin
        @(negedge clk);
        req_valid = '0;
        #1;
        check("rnd_no_ready", req_ready, 0);
        check("rnd_idle", busy, 0);
      end else begin
        w = model_pick(v);
        run_frame(v, d, w, d[w*W +: W], $urandom_range(0, 6), $urandom_range(0, 5), 1'b1);
      end
    end

    // Held requester: tx_done to next tx_byte_valid latency
    @(negedge clk);
    req_valid = 4'b0010;
    req_data  = 32'h00009900;
    #1;
    check("lat_ready", req_ready, 4'b0010);
    @(negedge clk);
    tx_active = 1'b1;
    @(negedge clk);
    tx_active = 1'b0;
    tx_done   = 1'b1;
    lat       = -1;
    ready_cnt = 0;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(negedge clk);
      tx_done = 1'b0;
      #1;
      if (req_ready[1]) ready_cnt++;
      if (tx_byte_valid) lat = k;
    end
    check("gap_latency", lat, 3);
    check("regrant_pulses", ready_cnt, 1);
    check("regrant_id", grant_id, 1);
    req_valid = '0;
    tx_active = 1'b1;
    @(negedge clk);
    tx_active = 1'b0;
    tx_done   = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
    model_ptr = 1;

    // Reset while waiting for tx_done
    @(negedge clk);
    req_valid = 4'b0001;
    req_data  = 32'h000000C3;
    @(negedge clk);
    req_valid = '0;
    tx_active = 1'b1;
    @(negedge clk);
    #1;
    check("mid_wait_busy", busy, 1);
    rst       = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    #1;
    check("mid_rst_valid", tx_byte_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_grant", grant_id, 0);
    check("mid_rst_ready", req_ready, 0);
    rst       = 1'b0;
    req_valid = '0;
    tx_active = 1'b0;
    model_ptr = 0;
    run_frame(4'b1111, 32'h44332211, model_pick(4'b1111), 8'h22, 0, 0, 1'b0);
    check("post_rst_first", grant_id, 1);

`ifdef UART_TX_ARB_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    model_ptr = 0;
    for (int i = 0; i < 3; i++) run_frame(4'b0100, 32'h00550000, 2, 8'h55, 1, 1, 1'b0);
    run_frame(4'b0001, 32'h00000066, 0, 8'h66, 1, 1, 1'b0);
    check("stat_cnt0", byte_cnt[0*16 +: 16], 1);
    check("stat_cnt1", byte_cnt[1*16 +: 16], 0);
    check("stat_cnt2", byte_cnt[2*16 +: 16], 3);
    check("stat_cnt3", byte_cnt[3*16 +: 16], 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
